alu_operand_wb: RTL and testbench



---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_operand_wb_if.sv | 41 ++++
 rtl/alu_regfile.sv | 34 +++
 rtl/alu_operand_wb.sv | 104 ++++++++++
 tb/tb_alu_operand_wb.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings and the EX-stage record for the
// operand-fetch / writeback stage around the 8-bit ALU.
package alu_pkg;

    localparam int DW    = 8;
    localparam int NREGS = 8;
    localparam int RW    = $clog2(NREGS);
    localparam int OPW   = 5;

    localparam logic [OPW-1:0] ADD   = 5'b00000;
    localparam logic [OPW-1:0] SUB   = 5'b00001;
    localparam logic [OPW-1:0] AND   = 5'b00010;
    localparam logic [OPW-1:0] OR    = 5'b00011;
    localparam logic [OPW-1:0] XOR   = 5'b00100;
    localparam logic [OPW-1:0] NOR   = 5'b00101;
    localparam logic [OPW-1:0] SLL   = 5'b00110;
    localparam logic [OPW-1:0] SRL   = 5'b00111;
    localparam logic [OPW-1:0] SRA   = 5'b01000;
    localparam logic [OPW-1:0] ROL   = 5'b01001;
    localparam logic [OPW-1:0] ROR   = 5'b01010;
    localparam logic [OPW-1:0] MUL   = 5'b01011;
    localparam logic [OPW-1:0] MULHU = 5'b01100;
    localparam logic [OPW-1:0] DIV   = 5'b01101;
    localparam logic [OPW-1:0] DIVU  = 5'b01110;

    // Everything the EX stage needs to present to the ALU and retire later.
    typedef struct packed {
        logic [OPW-1:0] oper;
        logic [RW-1:0]  rd;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } ex_t;

endpackage

// File: rtl/alu_operand_wb_if.sv
// Bundle of decoder, ALU, writeback and debug signals of the stage.
// slave = the stage itself, master = its surroundings.
interface alu_operand_wb_if;
    import alu_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_oper;
    logic [RW-1:0]  in_rd;
    logic [RW-1:0]  in_rs1;
    logic [RW-1:0]  in_rs2;
    logic           in_use_imm;
    logic [DW-1:0]  in_imm;
    logic           hold;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_oper;
    logic [DW-1:0]  alu_r;
    logic [7:0]     alu_flag;
    logic           wb_valid;
    logic [RW-1:0]  wb_rd;
    logic [DW-1:0]  wb_data;
    logic [7:0]     flag_q;
    logic [RW-1:0]  dbg_addr;
    logic [DW-1:0]  dbg_data;

    modport slave (
        input  in_valid, in_oper, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        input  hold, alu_r, alu_flag, dbg_addr,
        output in_ready, alu_a, alu_b, alu_oper,
        output wb_valid, wb_rd, wb_data, flag_q, dbg_data
    );

    modport master (
        output in_valid, in_oper, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        output hold, alu_r, alu_flag, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_oper,
        input  wb_valid, wb_rd, wb_data, flag_q, dbg_data
    );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x DW register file: two operand read ports, a debug read port and
// one synchronous write port. Register 0 always reads zero.
module alu_regfile
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [RW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [RW-1:0] raddr1_i,
    input  logic [RW-1:0] raddr2_i,
    input  logic [RW-1:0] dbgAddr_i,
    output logic [DW-1:0] rdata1_o,
    output logic [DW-1:0] rdata2_o,
    output logic [DW-1:0] dbgData_o
);

    logic [NREGS-1:0][DW-1:0] regs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Address 0 is forced to zero on read so no write path can ever alter it.
    assign rdata1_o  = (raddr1_i  == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o  = (raddr2_i  == '0) ? '0 : regs_q[raddr2_i];
    assign dbgData_o = (dbgAddr_i == '0) ? '0 : regs_q[dbgAddr_i];

endmodule

// File: rtl/alu_operand_wb.sv
// Operand fetch with forwarding from the in-flight EX instruction, a registered
// EX stage feeding the external ALU, and writeback of its result and flags.
module alu_operand_wb
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    alu_operand_wb_if.slave  bus
);

    ex_t           ex_q,       ex_d;
    logic          exValid_q,  exValid_d;
    logic          wbValid_q,  wbValid_d;
    logic [RW-1:0] wbRd_q,     wbRd_d;
    logic [DW-1:0] wbData_q,   wbData_d;
    logic [7:0]    flag_q,     flag_d;

    logic          rfWe;
    logic [DW-1:0] rs1Data;
    logic [DW-1:0] rs2Data;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;

    alu_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rfWe),
        .waddr_i   (ex_q.rd),
        .wdata_i   (bus.alu_r),
        .raddr1_i  (bus.in_rs1),
        .raddr2_i  (bus.in_rs2),
        .dbgAddr_i (bus.dbg_addr),
        .rdata1_o  (rs1Data),
        .rdata2_o  (rs2Data),
        .dbgData_o (bus.dbg_data)
    );

    // The EX result is written on the same edge the next instruction is
    // captured, so a dependent reader must take alu_r directly.
    always_comb begin
        opA = rs1Data;
        opB = rs2Data;
        if (exValid_q && (ex_q.rd == bus.in_rs1) && (bus.in_rs1 != '0)) begin
            opA = bus.alu_r;
        end
        if (bus.in_use_imm) begin
            opB = bus.in_imm;
        end else if (exValid_q && (ex_q.rd == bus.in_rs2) && (bus.in_rs2 != '0)) begin
            opB = bus.alu_r;
        end
    end

    always_comb begin
        ex_d      = ex_q;
        exValid_d = exValid_q;
        wbValid_d = 1'b0;
        wbRd_d    = wbRd_q;
        wbData_d  = wbData_q;
        flag_d    = flag_q;
        rfWe      = 1'b0;
        if (!bus.hold) begin
            if (exValid_q) begin
                wbValid_d = 1'b1;
                wbRd_d    = ex_q.rd;
                wbData_d  = bus.alu_r;
                flag_d    = bus.alu_flag;
                rfWe      = (ex_q.rd != '0);
            end
            exValid_d = bus.in_valid;
            // When draining, the ALU inputs keep their last values.
            if (bus.in_valid) begin
                ex_d = '{oper: bus.in_oper, rd: bus.in_rd, a: opA, b: opB};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            exValid_q <= 1'b0;
            wbValid_q <= 1'b0;
            wbRd_q    <= '0;
            wbData_q  <= '0;
            flag_q    <= '0;
        end else begin
            ex_q      <= ex_d;
            exValid_q <= exValid_d;
            wbValid_q <= wbValid_d;
            wbRd_q    <= wbRd_d;
            wbData_q  <= wbData_d;
            flag_q    <= flag_d;
        end
    end

    assign bus.in_ready = ~bus.hold;
    assign bus.alu_a    = ex_q.a;
    assign bus.alu_b    = ex_q.b;
    assign bus.alu_oper = ex_q.oper;
    assign bus.wb_valid = wbValid_q;
    assign bus.wb_rd    = wbRd_q;
    assign bus.wb_data  = wbData_q;
    assign bus.flag_q   = flag_q;

endmodule

// File: tb/tb_alu_operand_wb.sv
// Directed bench for alu_operand_wb: a behavioural ALU closes the loop, expected
// writebacks are queued at issue time and a negedge monitor retires them.
module tb_alu_operand_wb;
    import alu_pkg::*;

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        logic [7:0]    flag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;
    int   cyc;
    int   wbCyc [NREGS];
    exp_t expQ [$];

    alu_operand_wb_if bus();

    alu_operand_wb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] aluModel(logic [4:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            DIVU:    return (b == 8'h00) ? 8'hFF : a / b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_r    = aluModel(bus.alu_oper, bus.alu_a, bus.alu_b);
    assign bus.alu_flag = {6'b0, bus.alu_r[7], (bus.alu_r == 8'h00)};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one instruction on the next edge; the expectation is queued only
    // when the instruction is supposed to retire.
    task automatic applyStimulus(input logic [4:0] oper, input logic [2:0] rd,
                                 input logic [2:0] rs1, input logic [2:0] rs2,
                                 input logic useImm, input logic [7:0] imm,
                                 input bit retire, input logic [7:0] expData,
                                 input logic [7:0] expFlag);
        exp_t e;
        bus.in_valid   = 1'b1;
        bus.in_oper    = oper;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_use_imm = useImm;
        bus.in_imm     = imm;
        if (retire) begin
            e.rd   = rd;
            e.data = expData;
            e.flag = expFlag;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic readReg(input logic [2:0] addr, input logic [7:0] exp);
        bus.dbg_addr = addr;
        #1;
        checkOutput($sformatf("dbg_r%0d", addr), 32'(bus.dbg_data), 32'(exp));
    endtask

    // Monitor: every writeback pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_wb: got rd=%0d data=0x%0h, expected no writeback",
                         bus.wb_rd, bus.wb_data);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("wb_rd",   32'(bus.wb_rd),   32'(e.rd));
                checkOutput("wb_data", 32'(bus.wb_data), 32'(e.data));
                checkOutput("flag_q",  32'(bus.flag_q),  32'(e.flag));
                wbCyc[bus.wb_rd] = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks         = 0;
        fails          = 0;
        cyc            = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_oper    = ADD;
        bus.in_rd      = '0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_use_imm = 1'b0;
        bus.in_imm     = '0;
        bus.hold       = 1'b0;
        bus.dbg_addr   = '0;
        foreach (wbCyc[i]) wbCyc[i] = 0;

        idle(3);
        for (int i = 0; i < NREGS; i++) readReg(3'(i), 8'h00);
        checkOutput("reset_wb_valid", 32'(bus.wb_valid), 32'(0));
        checkOutput("reset_flag_q",   32'(bus.flag_q),   32'(0));
        checkOutput("reset_alu_a",    32'(bus.alu_a),    32'(0));
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'(1));
        rst_n = 1'b1;
        idle(2);

        applyStimulus(ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 1'b1, 8'h05, 8'h00);
        idle(2);
        readReg(3'd1, 8'h05);

        // Back-to-back dependency: r3 = r2 + r2 with r2 still in EX.
        applyStimulus(ADD, 3'd2, 3'd1, 3'd0, 1'b1, 8'h03, 1'b1, 8'h08, 8'h00);
        applyStimulus(ADD, 3'd3, 3'd2, 3'd2, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00);
        idle(2);
        readReg(3'd2, 8'h08);
        readReg(3'd3, 8'h10);
        checkOutput("no_bubble", 32'(wbCyc[3] - wbCyc[2]), 32'(1));

        applyStimulus(DIVU, 3'd4, 3'd1, 3'd0, 1'b1, 8'h00, 1'b1, 8'hFF, 8'h02);
        applyStimulus(ADD,  3'd0, 3'd0, 3'd0, 1'b1, 8'h7F, 1'b1, 8'h7F, 8'h00);
        idle(2);
        readReg(3'd4, 8'hFF);
        readReg(3'd0, 8'h00);

        // r5 = 0x05 - 0x06 frozen in EX for three cycles.
        applyStimulus(SUB, 3'd5, 3'd1, 3'd0, 1'b1, 8'h06, 1'b1, 8'hFF, 8'h02);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", 32'(bus.in_ready), 32'(0));
            checkOutput("hold_wb_valid", 32'(bus.wb_valid), 32'(0));
            checkOutput("hold_alu_a",    32'(bus.alu_a),    32'(8'h05));
            checkOutput("hold_alu_b",    32'(bus.alu_b),    32'(8'h06));
            checkOutput("hold_alu_oper", 32'(bus.alu_oper), 32'(SUB));
        end
        readReg(3'd5, 8'h00);
        @(posedge clk);
        #1;
        bus.hold = 1'b0;
        idle(4);
        readReg(3'd5, 8'hFF);
        checkOutput("drain_alu_a", 32'(bus.alu_a), 32'(8'h05));
        checkOutput("drain_alu_b", 32'(bus.alu_b), 32'(8'h06));
        checkOutput("flag_before_reset", 32'(bus.flag_q), 32'(8'h02));

        // Reset while r6 = r1 + 0x80 sits in EX: it must never retire.
        applyStimulus(ADD, 3'd6, 3'd1, 3'd0, 1'b1, 8'h80, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wb_valid", 32'(bus.wb_valid), 32'(0));
        checkOutput("rst_flag_q",   32'(bus.flag_q),   32'(0));
        for (int i = 1; i < NREGS; i++) readReg(3'(i), 8'h00);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        readReg(3'd6, 8'h00);
        checkOutput("queue_empty", 32'(expQ.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
